add_round_key_stream: RTL
=========================

# add_round_key_stream

Parametrised, sequential AddRoundKey stage for the AES-128 encrypt datapath. It accepts state and round-key words in DW-bit beats over a valid/ready handshake, XORs them on the fly and assembles the 128-bit result. It presents the completed block with a round tag over a second valid/ready handshake. It sits between the key-schedule/state feeders and the SubBytes stage, and replaces the purely combinational AddRoundKey where narrow buses are used.

## Interface
- DW, 32, beat width in bits; legal values 8, 16, 32, 64, 128. BEATS = 128/DW.
- NR, 10, last round index; round tag counts 0..NR.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_state  in  DW  state slice for the current beat
- round_key  in  DW  round-key slice for the current beat
- rnd_clr  in  1  synchronous clear of round tag counter
- out_valid  out  1  out_state/out_round valid
- out_ready  in  1  downstream accepts block when out_valid && out_ready
- out_state  out  128  in_state XOR round_key, assembled block
- out_round  out  4  round index of presented block

## Operation
- Reset is synchronous and active-high; clock is clk, reset is rst.
- Two states: FILL (collecting beats, out_valid=0) and HOLD (block complete, out_valid=1).
- Beat k (k = 0..BEATS-1) writes in_state ^ round_key into out_state[127-k*DW -: DW]. Beat 0 is the most significant slice, i.e. AES byte 0 first.
- beat_cnt counts accepted beats, width clog2(BEATS) (0 bits when DW=128).
- FILL: in_ready=1. On an accepted beat with beat_cnt==BEATS-1, go to HOLD and set beat_cnt to 0. Otherwise increment beat_cnt.
- HOLD: in_ready = out_ready (combinational pass-through).
  - Output handshake without input beat: go to FILL.
  - Output handshake with simultaneous input beat: the beat writes slice 0 at the same edge and collection continues. When BEATS==1, stay in HOLD with the new block.
- Round tag round_cnt: increments on each output handshake; after a handshake with round_cnt==NR it wraps to 0. out_round = round_cnt.
- rnd_clr: sets round_cnt to 0 next edge. It has priority over a simultaneous increment. It does not affect beat collection or out_valid.
- out_state slices of a partially filled block hold stale data and are only meaningful while out_valid=1.
- rst asserted at any point, including mid-block or in HOLD: partial block discarded, state FILL, beat_cnt 0, round_cnt 0.

## Timing
- Reset values: out_valid=0, out_state=128'h0, out_round=0, in_ready=1 (FILL).
- Latency: last beat accepted at edge N gives out_valid=1 and the full out_state from cycle N+1 (registered output, no combinational in-to-out data path).
- Throughput: with out_ready held high, one block every BEATS cycles with no bubble. For DW=128 this is one block per cycle.
- out_state and out_round are stable while out_valid=1 and out_ready=0. Upstream must hold in_valid/data until in_ready.
- in_ready depends combinationally on out_ready only in HOLD.

## Test plan
- DW=128, single beat: in_state=c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9, round_key=ac19285777fad15c66dc2900f321415a. Expect out_valid next cycle, out_state=65d0e19ebe331895af15e0c93ae88893, out_round=0.
- DW=8, same vector over 16 beats with random in_valid gaps. Expect the identical result exactly one cycle after beat 15, and no early out_valid.
- DW=32, out_ready held low 5 cycles in HOLD. Expect in_ready=0, outputs stable. Then raise out_ready together with the next block's beat 0. Expect no lost beat and back-to-back blocks, 4 cycles apart.
- Round tag: stream 12 blocks with NR=10. Expect out_round sequence 0..10,0. Pulse rnd_clr during block 5's output handshake. Expect the next out_round=0.
- Reset mid-operation: DW=16, assert rst after 3 beats. Expect out_valid=0, out_state=0, out_round=0. Then a full 8-beat block yields the correct XOR with no residue from the aborted beats.

Source files
------------

// File: rtl/add_round_key_stream_if.sv
// Beat-in / block-out handshake bundle for add_round_key_stream.
// The upstream feeder and the downstream consumer share the master side; the stage itself is the slave.
interface add_round_key_stream_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_state;
  logic [DW-1:0] round_key;
  logic          rnd_clr;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_state;
  logic [3:0]    out_round;

  modport master (
    output in_valid, in_state, round_key, rnd_clr, out_ready,
    input  in_ready, out_valid, out_state, out_round
  );

  modport slave (
    input  in_valid, in_state, round_key, rnd_clr, out_ready,
    output in_ready, out_valid, out_state, out_round
  );
endinterface

// File: rtl/add_round_key_stream.sv
// Streaming AES-128 AddRoundKey: XORs DW-bit state/key beats into a 128-bit block,
// most significant slice first, and presents the finished block with a round tag.
module add_round_key_stream #(
  parameter int DW = 32,
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  add_round_key_stream_if.slave  bus
);

  localparam int              BEATS      = 128 / DW;
  localparam int              CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]   LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [3:0]      LAST_ROUND = 4'(NR);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]      round_cnt_q, round_cnt_d;
  logic [127:0]    out_state_q, out_state_d;
  logic [DW-1:0]   beat_xor;
  logic            in_fire;
  logic            out_fire;

  // A full block may only be replaced once the consumer takes it.
  assign bus.in_ready  = (state_q == S_FILL) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_state = out_state_q;
  assign bus.out_round = round_cnt_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign beat_xor = bus.in_state ^ bus.round_key;

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves it unassigned (no latch).
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    round_cnt_d = round_cnt_q;
    out_state_d = out_state_q;

    for (int k = 0; k < BEATS; k++) begin
      if (in_fire && (beat_cnt_q == CW'(k))) begin
        out_state_d[127 - k*DW -: DW] = beat_xor;
      end
    end

    unique case (state_q)
      S_FILL: begin
        if (in_fire) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = S_HOLD;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_fire) begin
          // A beat arriving with the handshake is slice 0 of the next block.
          if (in_fire && (BEATS == 1)) begin
            state_d = S_HOLD;
          end else if (in_fire) begin
            state_d    = S_FILL;
            beat_cnt_d = CW'(1);
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    if (bus.rnd_clr) begin
      round_cnt_d = '0;
    end else if (out_fire) begin
      round_cnt_d = (round_cnt_q == LAST_ROUND) ? 4'd0 : round_cnt_q + 4'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      beat_cnt_q  <= '0;
      round_cnt_q <= '0;
      // NOTE: the block register is reset because its zero value is visible on out_state.
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      round_cnt_q <= round_cnt_d;
      out_state_q <= out_state_d;
    end
  end

endmodule
